// File: rtl/int_fp_div.sv
// int_fp_div: iterative radix-2 restoring divider.
//   mode=1: FP16 quotient a/b (flush-to-zero, truncating, saturating to inf).
//   mode=0: unsigned INT_W-bit quotient in c[7:0] and remainder in c[15:8].
// Ports:
//   clk, rst         clock (rising edge) and asynchronous active-low reset
//   mode             1 = FP16, 0 = unsigned integer; sampled at input handshake
//   in_valid/ready   operand handshake; in_ready high only while idle
//   a, b             dividend / divisor
//   out_valid/ready  result handshake; result held until out_ready
//   c                registered result
//   div_zero         divisor was zero; meaningful only while out_valid=1
module int_fp_div #(
    parameter int unsigned EXP_BIAS = 15,
    parameter int unsigned INT_W    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mode,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] c,
    output logic        div_zero
);

    localparam int unsigned QW      = 12;  // FP quotient width {1,mant,guard}
    localparam int unsigned DW      = 11;  // divisor / partial remainder width
    localparam int unsigned CW      = 4;   // iteration counter width
    localparam int unsigned EW      = 8;   // signed exponent working width
    localparam int unsigned ITER_FP = 12;

    localparam logic signed [EW-1:0] E_MAX  = EW'(31);
    localparam logic signed [EW-1:0] E_ZERO = '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        PACK = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, state_n;

    // Registered outputs and their next values
    logic        in_ready_n;
    logic        out_valid_n;
    logic [15:0] c_n;
    logic        div_zero_n;

    // Divider datapath
    logic [DW-1:0] rem, rem_n;      // partial remainder
    logic [DW-1:0] dsr, dsr_n;      // divisor
    logic [QW-1:0] dvd, dvd_n;      // dividend bits still to shift in, MSB first
    logic [QW-1:0] quo, quo_n;      // quotient bits shifted in LSB first
    logic [CW-1:0] cnt, cnt_n;

    // Latched operand fields used when packing the result
    logic             mode_q, mode_qn;
    logic             sign_q, sign_qn;
    logic [4:0]       ea_q, ea_qn;
    logic [4:0]       eb_q, eb_qn;
    logic [INT_W-1:0] a_lo_q, a_lo_qn;
    logic             bzero_q, bzero_qn;   // divisor zero (FP exp==0 or int==0)
    logic             azero_q, azero_qn;   // FP dividend zero

    // Combinational helpers
    logic                 a_exp_zero_c;
    logic                 b_exp_zero_c;
    logic                 b_int_zero_c;
    logic [QW-1:0]        sh_c;
    logic signed [EW-1:0] e_c;
    logic [9:0]           mant_c;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            c         <= '0;
            div_zero  <= 1'b0;
            rem       <= '0;
            dsr       <= '0;
            dvd       <= '0;
            quo       <= '0;
            cnt       <= '0;
            mode_q    <= 1'b0;
            sign_q    <= 1'b0;
            ea_q      <= '0;
            eb_q      <= '0;
            a_lo_q    <= '0;
            bzero_q   <= 1'b0;
            azero_q   <= 1'b0;
        end else begin
            state     <= state_n;
            in_ready  <= in_ready_n;
            out_valid <= out_valid_n;
            c         <= c_n;
            div_zero  <= div_zero_n;
            rem       <= rem_n;
            dsr       <= dsr_n;
            dvd       <= dvd_n;
            quo       <= quo_n;
            cnt       <= cnt_n;
            mode_q    <= mode_qn;
            sign_q    <= sign_qn;
            ea_q      <= ea_qn;
            eb_q      <= eb_qn;
            a_lo_q    <= a_lo_qn;
            bzero_q   <= bzero_qn;
            azero_q   <= azero_qn;
        end
    end

    // Next-state, datapath and output logic
    always_comb begin
        state_n    = state;
        c_n        = c;
        div_zero_n = div_zero;
        rem_n      = rem;
        dsr_n      = dsr;
        dvd_n      = dvd;
        quo_n      = quo;
        cnt_n      = cnt;
        mode_qn    = mode_q;
        sign_qn    = sign_q;
        ea_qn      = ea_q;
        eb_qn      = eb_q;
        a_lo_qn    = a_lo_q;
        bzero_qn   = bzero_q;
        azero_qn   = azero_q;

        a_exp_zero_c = (a[14:10] == 5'd0);
        b_exp_zero_c = (b[14:10] == 5'd0);
        b_int_zero_c = (b[INT_W-1:0] == '0);
        sh_c         = {rem, dvd[QW-1]};
        e_c          = EW'(ea_q) - EW'(eb_q) + EW'(EXP_BIAS) - EW'(!quo[QW-1]);
        mant_c       = quo[QW-1] ? quo[10:1] : quo[9:0];

        case (state)
            IDLE: begin
                if (in_valid) begin
                    mode_qn  = mode;
                    sign_qn  = a[15] ^ b[15];
                    ea_qn    = a[14:10];
                    eb_qn    = b[14:10];
                    a_lo_qn  = a[INT_W-1:0];
                    bzero_qn = mode ? b_exp_zero_c : b_int_zero_c;
                    azero_qn = mode & a_exp_zero_c;
                    quo_n    = '0;
                    if (mode) begin
                        // Numerator {1,ma}<<11: top 10 bits seed the remainder
                        // (quotient fits 12 bits), remaining 12 bits shift in.
                        rem_n = DW'({1'b1, a[9:1]});
                        dvd_n = {a[0], 11'b0};
                        dsr_n = {1'b1, b[9:0]};
                        cnt_n = CW'(ITER_FP);
                    end else begin
                        rem_n = '0;
                        dvd_n = {a[INT_W-1:0], {(QW-INT_W){1'b0}}};
                        dsr_n = DW'(b[INT_W-1:0]);
                        cnt_n = CW'(INT_W);
                    end
                    if (mode ? (a_exp_zero_c | b_exp_zero_c) : b_int_zero_c) begin
                        state_n = PACK;
                    end else begin
                        state_n = CALC;
                    end
                end
            end

            CALC: begin
                // One restoring step: trial subtract, keep if non-negative
                if (sh_c >= {1'b0, dsr}) begin
                    rem_n = DW'(sh_c - {1'b0, dsr});
                    quo_n = {quo[QW-2:0], 1'b1};
                end else begin
                    rem_n = sh_c[DW-1:0];
                    quo_n = {quo[QW-2:0], 1'b0};
                end
                dvd_n = {dvd[QW-2:0], 1'b0};
                cnt_n = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_n = PACK;
                end
            end

            PACK: begin
                div_zero_n = bzero_q;
                if (!mode_q) begin
                    if (bzero_q) begin
                        c_n = {8'(a_lo_q), 8'({INT_W{1'b1}})};
                    end else begin
                        c_n = {8'(rem[INT_W-1:0]), 8'(quo[INT_W-1:0])};
                    end
                end else if (bzero_q) begin
                    c_n = {sign_q, 5'h1F, 10'h0};
                end else if (azero_q) begin
                    c_n = {sign_q, 15'h0};
                end else if (e_c >= E_MAX) begin
                    c_n = {sign_q, 5'h1F, 10'h0};
                end else if (e_c <= E_ZERO) begin
                    c_n = {sign_q, 15'h0};
                end else begin
                    c_n = {sign_q, e_c[4:0], mant_c};
                end
                state_n = DONE;
            end

            DONE: begin
                if (out_ready) begin
                    div_zero_n = 1'b0;
                    state_n    = IDLE;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase

        in_ready_n  = (state_n == IDLE);
        out_valid_n = (state_n == DONE);
    end

endmodule
